// File: rtl/uart_tx_pkg.sv
// Shared UART parameters: baud constant, TX state encodings, frame sizes.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_tx_pkg;

    localparam int unsigned clocksPerBit = 16;
    localparam int unsigned dataBits     = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned frameBits = 11;
`else
    localparam int unsigned frameBits = 10;
`endif

    // TX encodings, named apart from the receiver's states.
    typedef enum logic [2:0] {
        txIdle   = 3'd0,
        txStart  = 3'd1,
        txData   = 3'd2,
        txParity = 3'd3,
        txStop   = 3'd4
    } txState_t;

    function automatic logic evenParity(input logic [7:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1 while enabled and pulses
// bitTick on the terminal count, then wraps to 0.
module uart_baud_counter
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = clocksPerBit
) (
    input  logic clkRx,
    input  logic resetreg,
    input  logic clear,
    input  logic enable,
    output logic bitTick
);

    localparam logic [15:0] terminalCount = 16'(CLOCKS_PER_BIT - 1);

    logic [15:0] cycleCount;

    assign bitTick = enable && (cycleCount == terminalCount);

    // Cycle counter with synchronous clear and wrap at terminal count.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            cycleCount <= 16'd0;
        end else if (clear || bitTick) begin
            cycleCount <= 16'd0;
        end else if (enable) begin
            cycleCount <= cycleCount + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, start low, stop high.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
//
// state    | meaning
// ---------+-----------------------------------------------
// txIdle   | line high, ready for a byte
// txStart  | start bit (low)
// txData   | shifting data bits, LSB first
// txParity | even-parity bit (parity builds only)
// txStop   | stop bit (high); txDone pulses on exit
module uart_tx #(
    parameter int unsigned CLOCKS_PER_BIT = uart_tx_pkg::clocksPerBit
) (
    input  logic       clkRx,
    input  logic       resetreg,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       serialOutput,
    output logic       txBusy,
    output logic       txDone
);

    import uart_tx_pkg::*;

    // The txData port hides the package literal of the same name.
    localparam txState_t stData = uart_tx_pkg::txData;

    txState_t   state, nextState;
    logic [7:0] shiftReg, shiftNext;
    logic [2:0] bitCount, bitNext;
    logic       lineNext;
    logic       doneNext;
    logic       clearCount;
    logic       bitTick;
`ifdef UART_TX_PARITY_EN
    logic       parityBit, parityNext;
`endif

    uart_baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) baudCounter (
        .clkRx   (clkRx),
        .resetreg(resetreg),
        .clear   (clearCount),
        .enable  (state != txIdle),
        .bitTick (bitTick)
    );

    assign txReady = (state == txIdle);
    assign txBusy  = (state != txIdle);

    // State, data path and registered line/done outputs.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            state        <= txIdle;
            shiftReg     <= 8'd0;
            bitCount     <= 3'd0;
            serialOutput <= 1'b1;
            txDone       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit    <= 1'b0;
`endif
        end else begin
            state        <= nextState;
            shiftReg     <= shiftNext;
            bitCount     <= bitNext;
            serialOutput <= lineNext;
            txDone       <= doneNext;
`ifdef UART_TX_PARITY_EN
            parityBit    <= parityNext;
`endif
        end
    end

    // Next-state logic; the line value is derived from the next state so the
    // output register already holds the new bit in the cycle after the edge.
    always_comb begin
        nextState  = state;
        shiftNext  = shiftReg;
        bitNext    = bitCount;
        doneNext   = 1'b0;
        clearCount = 1'b0;
        lineNext   = 1'b1;
`ifdef UART_TX_PARITY_EN
        parityNext = parityBit;
`endif
        case (state)
            txIdle: begin
                if (txValid) begin
                    nextState  = txStart;
                    shiftNext  = txData;
                    bitNext    = 3'd0;
                    clearCount = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parityNext = evenParity(txData);
`endif
                end
            end
            txStart: begin
                if (bitTick) nextState = stData;
            end
            stData: begin
                if (bitTick) begin
                    shiftNext = {1'b0, shiftReg[7:1]};
                    bitNext   = bitCount + 3'd1;
                    if (bitCount == 3'(dataBits - 1)) begin
`ifdef UART_TX_PARITY_EN
                        nextState = txParity;
`else
                        nextState = txStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            txParity: begin
                if (bitTick) nextState = txStop;
            end
`endif
            txStop: begin
                if (bitTick) begin
                    nextState = txIdle;
                    doneNext  = 1'b1;
                end
            end
            default: nextState = txIdle;
        endcase

        case (nextState)
            txStart:  lineNext = 1'b0;
            stData:   lineNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            txParity: lineNext = parityNext;
`endif
            default:  lineNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int C   = 4;
    localparam int C16 = 16;
`ifdef UART_TX_PARITY_EN
    localparam int F   = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int F   = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clkRx = 1'b0;
    logic       resetreg = 1'b0;
    logic [7:0] dataIn = 8'd0;
    logic       validIn = 1'b0;
    logic       txReady, serialOutput, txBusy, txDone;
    logic [7:0] dataIn16 = 8'd0;
    logic       validIn16 = 1'b0;
    logic       txReady16, serialOutput16, txBusy16, txDone16;

    int tests = 0;
    int fails = 0;

    always #5 clkRx = ~clkRx;

    uart_tx #(.CLOCKS_PER_BIT(C)) dut (
        .clkRx(clkRx), .resetreg(resetreg), .txData(dataIn), .txValid(validIn),
        .txReady(txReady), .serialOutput(serialOutput), .txBusy(txBusy), .txDone(txDone)
    );

    uart_tx #(.CLOCKS_PER_BIT(C16)) dut16 (
        .clkRx(clkRx), .resetreg(resetreg), .txData(dataIn16), .txValid(validIn16),
        .txReady(txReady16), .serialOutput(serialOutput16), .txBusy(txBusy16), .txDone(txDone16)
    );

    // Reference frame: bit index -> line level.
    function automatic logic expBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        @(negedge clkRx);
        resetreg = 1'b1;
        #1;
        tests++;
        if ({serialOutput, txReady, txBusy, txDone} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_state got %b want 1100", {serialOutput, txReady, txBusy, txDone});
        end
        @(negedge clkRx);
        resetreg = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clkRx);
            tests++;
            if ({serialOutput, txReady, txBusy, txDone} !== 4'b1100) begin
                fails++;
                $display("FAIL idle cycle %0d got %b want 1100", i, {serialOutput, txReady, txBusy, txDone});
            end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5;
        bytes[1] = 8'($urandom);
        bytes[2] = 8'($urandom);
        foreach (bytes[j]) begin
            tests++;
            if (txReady !== 1'b1) begin
                fails++;
                $display("FAIL single_ready got %b want 1", txReady);
            end
            validIn = 1'b1;
            dataIn  = bytes[j];
            @(negedge clkRx);
            validIn = 1'b0;
            for (int k = 0; k < F*C; k++) begin
                tests++;
                if ({serialOutput, txReady, txBusy, txDone} !== {expBit(bytes[j], k/C), 3'b010}) begin
                    fails++;
                    $display("FAIL single_frame byte=%h k=%0d got %b want %b", bytes[j], k,
                             {serialOutput, txReady, txBusy, txDone}, {expBit(bytes[j], k/C), 3'b010});
                end
                dataIn = 8'($urandom);
                @(negedge clkRx);
            end
            tests++;
            if ({serialOutput, txReady, txBusy, txDone} !== 4'b1101) begin
                fails++;
                $display("FAIL single_done byte=%h got %b want 1101", bytes[j], {serialOutput, txReady, txBusy, txDone});
            end
            @(negedge clkRx);
            tests++;
            if ({serialOutput, txReady, txBusy, txDone} !== 4'b1100) begin
                fails++;
                $display("FAIL single_after_done got %b want 1100", {serialOutput, txReady, txBusy, txDone});
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] bytes [3];
        bytes[0] = 8'h07;
        bytes[1] = 8'h03;
        bytes[2] = 8'($urandom);
        foreach (bytes[j]) begin
            validIn = 1'b1;
            dataIn  = bytes[j];
            @(negedge clkRx);
            validIn = 1'b0;
            for (int k = 0; k < F*C; k++) begin
                tests++;
                if ({serialOutput, txBusy} !== {expBit(bytes[j], k/C), 1'b1}) begin
                    fails++;
                    $display("FAIL parity_frame byte=%h k=%0d got %b want %b", bytes[j], k,
                             {serialOutput, txBusy}, {expBit(bytes[j], k/C), 1'b1});
                end
                @(negedge clkRx);
            end
            tests++;
            if ({serialOutput, txReady, txBusy, txDone} !== 4'b1101) begin
                fails++;
                $display("FAIL parity_done byte=%h got %b want 1101", bytes[j], {serialOutput, txReady, txBusy, txDone});
            end
            @(negedge clkRx);
        end
    endtask

    task automatic test_back_to_back();
        validIn = 1'b1;
        dataIn  = 8'h00;
        @(negedge clkRx);
        for (int k = 0; k < F*C; k++) begin
            tests++;
            if ({serialOutput, txBusy, txDone} !== {expBit(8'h00, k/C), 2'b10}) begin
                fails++;
                $display("FAIL b2b_first k=%0d got %b want %b", k, {serialOutput, txBusy, txDone},
                         {expBit(8'h00, k/C), 2'b10});
            end
            dataIn = (k == F*C-1) ? 8'hFF : 8'($urandom);
            @(negedge clkRx);
        end
        tests++;
        if ({serialOutput, txReady, txBusy, txDone} !== 4'b1101) begin
            fails++;
            $display("FAIL b2b_gap got %b want 1101", {serialOutput, txReady, txBusy, txDone});
        end
        @(negedge clkRx);
        for (int k = 0; k < F*C; k++) begin
            tests++;
            if ({serialOutput, txBusy, txDone} !== {expBit(8'hFF, k/C), 2'b10}) begin
                fails++;
                $display("FAIL b2b_second k=%0d got %b want %b", k, {serialOutput, txBusy, txDone},
                         {expBit(8'hFF, k/C), 2'b10});
            end
            validIn = 1'b0;
            dataIn  = 8'($urandom);
            @(negedge clkRx);
        end
        tests++;
        if ({serialOutput, txReady, txBusy, txDone} !== 4'b1101) begin
            fails++;
            $display("FAIL b2b_second_done got %b want 1101", {serialOutput, txReady, txBusy, txDone});
        end
        @(negedge clkRx);
        tests++;
        if ({serialOutput, txReady, txBusy, txDone} !== 4'b1100) begin
            fails++;
            $display("FAIL b2b_no_third got %b want 1100", {serialOutput, txReady, txBusy, txDone});
        end
    endtask

    task automatic test_reset_mid_frame();
        validIn = 1'b1;
        dataIn  = 8'h00;
        @(negedge clkRx);
        validIn = 1'b0;
        repeat (4*C + 1) @(negedge clkRx);
        tests++;
        if ({serialOutput, txBusy} !== 2'b01) begin
            fails++;
            $display("FAIL midreset_before got %b want 01", {serialOutput, txBusy});
        end
        #1 resetreg = 1'b1;
        #1;
        tests++;
        if ({serialOutput, txReady, txBusy, txDone} !== 4'b1100) begin
            fails++;
            $display("FAIL midreset_async got %b want 1100", {serialOutput, txReady, txBusy, txDone});
        end
        #1 resetreg = 1'b0;
        validIn = 1'b1;
        dataIn  = 8'h55;
        @(negedge clkRx);
        validIn = 1'b0;
        for (int k = 0; k < F*C; k++) begin
            tests++;
            if ({serialOutput, txBusy} !== {expBit(8'h55, k/C), 1'b1}) begin
                fails++;
                $display("FAIL midreset_new k=%0d got %b want %b", k, {serialOutput, txBusy},
                         {expBit(8'h55, k/C), 1'b1});
            end
            @(negedge clkRx);
        end
        tests++;
        if ({serialOutput, txReady, txDone} !== 3'b111) begin
            fails++;
            $display("FAIL midreset_done got %b want 111", {serialOutput, txReady, txDone});
        end
        @(negedge clkRx);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        logic [7:0] rx;
        bit found;
        bytes[0] = 8'h00;
        bytes[1] = 8'h5A;
        bytes[2] = 8'hFF;
        foreach (bytes[j]) begin
            validIn16 = 1'b1;
            dataIn16  = bytes[j];
            found = 1'b0;
            for (int t = 0; t < 50 && !found; t++) begin
                @(negedge clkRx);
                if (serialOutput16 === 1'b0) found = 1'b1;
            end
            validIn16 = 1'b0;
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL loopback_start byte=%h got no falling edge want start bit", bytes[j]);
            end else begin
                repeat (C16/2) @(negedge clkRx);
                tests++;
                if (serialOutput16 !== 1'b0) begin
                    fails++;
                    $display("FAIL loopback_midstart got %b want 0", serialOutput16);
                end
                rx = 8'd0;
                for (int i = 0; i < 8; i++) begin
                    repeat (C16) @(negedge clkRx);
                    rx[i] = serialOutput16;
                end
                if (PAR) repeat (C16) @(negedge clkRx);
                repeat (C16) @(negedge clkRx);
                tests++;
                if (serialOutput16 !== 1'b1) begin
                    fails++;
                    $display("FAIL loopback_stop got %b want 1", serialOutput16);
                end
                tests++;
                if (rx !== bytes[j]) begin
                    fails++;
                    $display("FAIL loopback_byte got %h want %h", rx, bytes[j]);
                end
                found = 1'b0;
                for (int t = 0; t < 3*C16 && !found; t++) begin
                    @(negedge clkRx);
                    if (txDone16 === 1'b1) found = 1'b1;
                end
                tests++;
                if (!found) begin
                    fails++;
                    $display("FAIL loopback_done byte=%h got no txDone want pulse", bytes[j]);
                end
                @(negedge clkRx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
